i2c_target: RTL

- I2C target (slave) responder: the far end of the bus driven by our I2C master.
- Oversamples SCL/SDA on the 50 MHz system clock and detects START, repeated START and STOP.
- Decodes [dev addr+R/W][reg addr][data...] transactions and exposes them as a simple register-file write/read port for local peripherals.
- Write-with-auto-increment and current-pointer read are supported.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_line_sync.sv | 27 ++
 rtl/i2c_target.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM encodings, bus bit constants and default address for the I2C target.
package i2c_pkg;
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_REG       = 4'd3,
    S_REG_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8,
    S_IGNORE    = 4'd9
  } state_t;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  localparam logic [6:0] DEF_DEV_ADDR = 7'h3C;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizer plus history flop giving level and rise/fall pulses for one bus line.
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic r_hist;
  // Reset to the idle-high bus level so reset never fabricates an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '1;
      r_hist <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_line};
      r_hist <= r_sync[STAGES-1];
    end
  end
  assign o_level = r_sync[STAGES-1];
  assign o_rise = o_level & ~r_hist;
  assign o_fall = ~o_level & r_hist;
endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target exposing bus transactions as an auto-incrementing register write/read port.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic [3:0] states
);
  logic w_scl, w_scl_rise, w_scl_fall, w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic [7:0] w_byte;
  state_t r_state, w_state_n;
  logic [2:0] r_cnt, w_cnt_n;
  logic [7:0] r_shift, w_shift_n, r_ptr, w_ptr_n, r_wr_addr, w_wr_addr_n, r_wr_data, w_wr_data_n;
  logic r_rw, w_rw_n, r_sda_low, w_sda_n, r_wr_en, w_wr_en_n, r_busy, w_busy_n, r_load, w_load_n;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .reset(reset), .i_line(i2c_scl),
    .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );
  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda (
    .clk(clk), .reset(reset), .i_line(i2c_sda),
    .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  // An SDA edge coinciding with an SCL edge is data, not a bus condition.
  assign w_start = w_sda_fall & w_scl & ~w_scl_rise;
  assign w_stop = w_sda_rise & w_scl & ~w_scl_rise;
  assign w_byte = {r_shift[6:0], w_sda};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n = r_cnt;
    w_shift_n = r_shift;
    w_rw_n = r_rw;
    w_ptr_n = r_wr_en ? r_ptr + 8'd1 : r_ptr;
    w_sda_n = r_sda_low;
    w_wr_en_n = 1'b0;
    w_wr_addr_n = r_wr_addr;
    w_wr_data_n = r_wr_data;
    w_busy_n = r_busy;
    w_load_n = r_load;
    if (w_start) begin
      w_state_n = S_ADDR;
      w_cnt_n = 3'd7;
      w_sda_n = 1'b0;
    end else if (w_stop) begin
      w_state_n = S_IDLE;
      w_sda_n = 1'b0;
      w_busy_n = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_REG, S_WDATA: if (w_scl_rise) begin
          w_shift_n = w_byte;
          w_cnt_n = r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            if (r_state == S_ADDR) begin
              w_state_n = (w_byte[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
              w_busy_n = (w_byte[7:1] == DEV_ADDR);
              w_rw_n = w_byte[0];
            end else if (r_state == S_REG) begin
              w_ptr_n = w_byte;
              w_state_n = S_REG_ACK;
            end else w_state_n = S_WDATA_ACK;
          end
        end
        // First fall after the byte opens the ACK slot, the next one closes it.
        S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: if (w_scl_fall) begin
          if (!r_sda_low) begin
            w_sda_n = 1'b1;
            w_wr_en_n = (r_state == S_WDATA_ACK);
            w_wr_addr_n = (r_state == S_WDATA_ACK) ? r_ptr : r_wr_addr;
            w_wr_data_n = (r_state == S_WDATA_ACK) ? r_shift : r_wr_data;
          end else if (r_state == S_ADDR_ACK && r_rw) begin
            w_state_n = S_RDATA;
            w_shift_n = rd_data;
            w_sda_n = ~rd_data[7];
            w_cnt_n = 3'd7;
            w_load_n = 1'b0;
          end else begin
            w_state_n = (r_state == S_ADDR_ACK) ? S_REG : S_WDATA;
            w_sda_n = 1'b0;
            w_cnt_n = 3'd7;
          end
        end
        S_RDATA: if (w_scl_fall) begin
          if (r_load) begin
            w_shift_n = rd_data;
            w_sda_n = ~rd_data[7];
            w_cnt_n = 3'd7;
            w_load_n = 1'b0;
          end else if (r_cnt == 3'd0) begin
            w_sda_n = 1'b0;
            w_state_n = S_RDATA_ACK;
          end else begin
            w_shift_n = {r_shift[6:0], 1'b0};
            w_sda_n = ~r_shift[6];
            w_cnt_n = r_cnt - 3'd1;
          end
        end
        S_RDATA_ACK: if (w_scl_rise) begin
          w_state_n = (w_sda == NACK) ? S_IGNORE : S_RDATA;
          w_busy_n = (w_sda != NACK);
          w_ptr_n = (w_sda == NACK) ? r_ptr : r_ptr + 8'd1;
          w_load_n = (w_sda != NACK);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 3'd7;
      r_shift <= 8'd0;
      r_rw <= 1'b0;
      r_ptr <= 8'd0;
      r_sda_low <= 1'b0;
      r_wr_en <= 1'b0;
      r_wr_addr <= 8'd0;
      r_wr_data <= 8'd0;
      r_busy <= 1'b0;
      r_load <= 1'b0;
    end else begin
      r_cnt <= w_cnt_n;
      r_shift <= w_shift_n;
      r_rw <= w_rw_n;
      r_ptr <= w_ptr_n;
      r_sda_low <= w_sda_n;
      r_wr_en <= w_wr_en_n;
      r_wr_addr <= w_wr_addr_n;
      r_wr_data <= w_wr_data_n;
      r_busy <= w_busy_n;
      r_load <= w_load_n;
    end
  end

  assign i2c_sda = r_sda_low ? ACK : 1'bz;
  assign wr_en = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign rd_addr = r_ptr;
  assign busy = r_busy;
  assign states = r_state;
endmodule
